// File: rtl/mult_8x8_seq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mult_8x8_seq_sched
//  Description : 8x8 multiplier built by time-sharing one external 4x4
//                multiplier over four quadrant cycles (Q0..Q3). Partial
//                products are combined by bitwise OR (ACCUM=0) or by an
//                exact 16-bit add (ACCUM=1). A zero operand can skip
//                straight to the result (ZSKIP=1).
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                in_valid/in_ready, A, B  - operand handshake (8-bit each)
//                mul_a, mul_b, mul_sel    - nibbles and unit select sent to
//                                           the shared 4x4 multiplier
//                mul_r          - combinational 4x4 product returned
//                out_valid/out_ready, R   - result handshake (16-bit)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_8x8_seq_sched #(
    parameter int ACCUM = 0,
    parameter int ZSKIP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic        mul_sel,
    input  logic [7:0]  mul_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] R
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_Q0   = 3'd1;
    localparam logic [2:0] S_Q1   = 3'd2;
    localparam logic [2:0] S_Q2   = 3'd3;
    localparam logic [2:0] S_Q3   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [7:0]  r_ar;
    logic [7:0]  r_br;
    logic [15:0] r_acc;
    logic [15:0] w_acc_next;
    logic [15:0] w_term;
    logic        w_xfer;
    logic        w_zero;
    logic        w_in_q;

    assign w_xfer = in_valid && (r_state == S_IDLE);
    assign w_zero = (ZSKIP != 0) && ((A == 8'h00) || (B == 8'h00));
    assign w_in_q = (r_state == S_Q0) || (r_state == S_Q1) ||
                    (r_state == S_Q2) || (r_state == S_Q3);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = w_zero ? S_DONE : S_Q0;
            S_Q0:    w_next = S_Q1;
            S_Q1:    w_next = S_Q2;
            S_Q2:    w_next = S_Q3;
            S_Q3:    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: quadrant schedule and the shifted partial product
    always_comb begin
        mul_a     = 4'h0;
        mul_b     = 4'h0;
        mul_sel   = 1'b0;
        w_term    = 16'h0000;
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        R         = (r_state == S_DONE) ? r_acc : 16'h0000;
        case (r_state)
            S_Q0: begin
                mul_a  = r_ar[3:0];
                mul_b  = r_br[3:0];
                w_term = {8'h00, mul_r};
            end
            S_Q1: begin
                mul_a   = r_ar[3:0];
                mul_b   = r_br[7:4];
                mul_sel = 1'b1;
                w_term  = {4'h0, mul_r, 4'h0};
            end
            S_Q2: begin
                mul_a   = r_ar[7:4];
                mul_b   = r_br[3:0];
                mul_sel = 1'b1;
                w_term  = {4'h0, mul_r, 4'h0};
            end
            S_Q3: begin
                mul_a   = r_ar[7:4];
                mul_b   = r_br[7:4];
                mul_sel = 1'b1;
                w_term  = {mul_r, 8'h00};
            end
            default: ;
        endcase
    end

    // Combine operator: the sum of the four weighted 4x4 products never
    // exceeds 0xFE01, so the 16-bit add cannot overflow.
    generate
        if (ACCUM != 0) begin : g_accum_add
            assign w_acc_next = r_acc + w_term;
        end else begin : g_accum_or
            assign w_acc_next = r_acc | w_term;
        end
    endgenerate

    // Operand latches and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar  <= 8'h00;
            r_br  <= 8'h00;
            r_acc <= 16'h0000;
        end else if (w_xfer) begin
            r_ar  <= A;
            r_br  <= B;
            r_acc <= 16'h0000;
        end else if (w_in_q) begin
            r_acc <= w_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/mult_8x8_seq_sched.md
MULT_8X8_SEQ_SCHED -- requirements
Module: mult_8x8_seq_sched

Interface
REQ-001 The block SHALL have parameter ACCUM, default 0, meaning partial-product combine mode: 0 = bitwise OR, 1 = exact binary add.
REQ-002 The block SHALL have parameter ZSKIP, default 1, meaning 1 = zero-operand early termination enabled, 0 = disabled.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  operand pair A/B offered.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: A  input  8  multiplicand.
REQ-008 Port: B  input  8  multiplier.
REQ-009 Port: mul_a  output  4  nibble driven to the shared external 4x4 multiplier.
REQ-010 Port: mul_b  output  4  nibble driven to the shared external 4x4 multiplier.
REQ-011 Port: mul_sel  output  1  4x4 variant select: 0 = low-quadrant unit, 1 = upper-quadrant unit.
REQ-012 Port: mul_r  input  8  combinational 4x4 product returned in the same cycle.
REQ-013 Port: out_valid  output  1  result R valid.
REQ-014 Port: out_ready  input  1  consumer accepts R.
REQ-015 Port: R  output  16  combined product.

Function
REQ-016 FSM states SHALL be IDLE, Q0, Q1, Q2, Q3, DONE; one state per cycle except IDLE and DONE, which hold.
REQ-017 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1 at a clock edge.
REQ-018 On transfer, A and B SHALL be latched into internal registers Ar/Br and the accumulator SHALL be cleared to 0; later changes on A/B SHALL have no effect on the operation.
REQ-019 On transfer with ZSKIP=1 and (A==0 or B==0), next state SHALL be DONE with accumulator 0; otherwise next state SHALL be Q0.
REQ-020 The quadrant schedule SHALL be: Q0: mul_a=Ar[3:0], mul_b=Br[3:0], mul_sel=0, weight 0; Q1: Ar[3:0], Br[7:4], mul_sel=1, weight 4; Q2: Ar[7:4], Br[3:0], mul_sel=1, weight 4; Q3: Ar[7:4], Br[7:4], mul_sel=1, weight 8.
REQ-021 In each Qn state the accumulator SHALL update to acc OP (zero-extended mul_r << weight), with OP = OR when ACCUM=0 and 16-bit add when ACCUM=1; no carry beyond bit 15 exists by construction.
REQ-022 In IDLE and DONE, mul_a, mul_b and mul_sel SHALL be 0.
REQ-023 Transitions SHALL be Q0->Q1->Q2->Q3->DONE, unconditional.
REQ-024 In DONE, out_valid SHALL be 1 and R SHALL equal the accumulator; R SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 DONE->IDLE SHALL occur at the edge where out_ready=1; in_ready SHALL rise the following cycle (no same-cycle accept-and-release).
REQ-026 Latency SHALL be 5 cycles (transfer edge to first out_valid=1 cycle) on the full path and 1 cycle on the zero-skip path.
REQ-027 Throughput SHALL be at most one operation per 6 cycles on the full path with out_ready held at 1.
REQ-028 R SHALL be 0 whenever out_valid=0.

Reset
REQ-029 While rst=1 at a clock edge, the state SHALL go to IDLE, Ar, Br and the accumulator SHALL be cleared to 0, out_valid=0, R=0, and in_ready=1 from the cycle after reset.
REQ-030 Reset asserted mid-operation (any Qn or DONE) SHALL abort the operation with no result presented and no partial state retained.

Verification
REQ-031 ACCUM=0, exact 4x4 model, A=0xFF, B=0xFF, out_ready=1 -> mul_sel sequence 0,1,1,1; R=0xEFF1 with out_valid at cycle 5.
REQ-032 ACCUM=1, same stimulus -> R=0xFE01; also A=0x12, B=0x34 -> R=0x03A8 (ACCUM=1) and R=0x0368 (ACCUM=0).
REQ-033 ZSKIP=1, A=0x00, B=0x5A -> out_valid at cycle 1, R=0x0000, mul_a/mul_b stay 0; with ZSKIP=0 -> full 5-cycle path, R=0x0000.
REQ-034 Backpressure: out_ready=0 for 3 cycles in DONE -> R, out_valid stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
REQ-035 rst=1 during Q2 -> next cycle state IDLE, out_valid=0, R=0, and the next transfer (A=0x12, B=0x34, ACCUM=0) -> R=0x0368 unaffected by the aborted operation.
REQ-036 A/B changed during Q0..Q3 and in_valid held at 1 throughout -> result uses the latched operands and no second transfer occurs until IDLE.
